// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if
//   Groups every non-clock signal of the Ethernet transmit scheduler:
//   the ACK request FIFO, the DATA request / tx_len FIFOs, the framer
//   launch/handshake signals and the status outputs.
// Modports
//   master : the scheduler. It drives the pops, the frame launch fields,
//            frm_abort, len_err and frames_sent.
//   slave  : the environment (FIFOs and framer). It drives the empty
//            flags, the FIFO heads and frm_done.
interface eth_tx_sched_if;
  logic        ack_empty;
  logic        ack_data;
  logic        ack_re;
  logic        send_data_empty;
  logic        send_data_re;
  logic [15:0] tx_len;
  logic        frm_start;
  logic        frm_kind;
  logic        frm_ack;
  logic [15:0] frm_len;
  logic        frm_done;
  logic        frm_abort;
  logic        len_err;
  logic [15:0] frames_sent;

  modport master (
    input  ack_empty, ack_data, send_data_empty, tx_len, frm_done,
    output ack_re, send_data_re, frm_start, frm_kind, frm_ack, frm_len,
           frm_abort, len_err, frames_sent
  );

  modport slave (
    output ack_empty, ack_data, send_data_empty, tx_len, frm_done,
    input  ack_re, send_data_re, frm_start, frm_kind, frm_ack, frm_len,
           frm_abort, len_err, frames_sent
  );
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched
//   Single-clock scheduler for the Ethernet transmit framer. It arbitrates
//   between ACK requests and DATA requests, launches one frame at a time,
//   enforces an inter-frame gap, kills a frame the framer never finishes,
//   and stops a stream of ACKs from starving DATA.
// Ports
//   clk    : tx client clock
//   reset  : synchronous, active-high
//   bus    : eth_tx_sched_if.master
//              ack_empty/ack_data/ack_re          ACK FIFO
//              send_data_empty/send_data_re/tx_len DATA request + length FIFOs
//              frm_start/frm_kind/frm_ack/frm_len  frame launch and held fields
//              frm_done/frm_abort                  framer completion / watchdog kill
//              len_err, frames_sent                status
// Parameters
//   ACK_BURST  : max consecutive ACK grants while DATA is pending (1..15)
//   IFG_CYCLES : idle cycles after done/abort before the next grant (0..255)
//   TIMEOUT    : watchdog limit in cycles counted from the launch cycle
//   MAX_LEN    : largest DATA length; longer requests are clamped
module eth_tx_sched #(
  parameter int ACK_BURST  = 4,
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT    = 65535,
  parameter int MAX_LEN    = 1500
) (
  input  logic           clk,
  input  logic           reset,
  eth_tx_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam logic [3:0]  ACK_BURST_W = 4'(ACK_BURST);
  localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);
  // The watchdog register holds the cycles elapsed since launch; the frame
  // expires on the edge where that count reaches TIMEOUT, so the abort
  // pulse appears exactly TIMEOUT cycles after frm_start.
  localparam logic [19:0] TO_LAST     = 20'(TIMEOUT - 1);
  localparam logic [7:0]  IFG_LAST    = 8'(IFG_CYCLES - 1);
  // With no gap configured, a finished frame goes straight back to IDLE.
  localparam state_t      POST_FRAME  = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t      state_reg;
  logic [3:0]  burst_reg;
  logic [7:0]  gap_reg;
  logic [19:0] wd_reg;
  logic        zero_len_reg;

  logic        ack_re_reg;
  logic        send_data_re_reg;
  logic        frm_start_reg;
  logic        frm_kind_reg;
  logic        frm_ack_reg;
  logic [15:0] frm_len_reg;
  logic        frm_abort_reg;
  logic        len_err_reg;
  logic [15:0] frames_sent_reg;

  logic ack_pend;
  logic data_pend;
  logic grant_data;
  logic grant_ack;
  logic len_zero;
  logic len_big;

  assign ack_pend   = !bus.ack_empty;
  assign data_pend  = !bus.send_data_empty;
  // DATA wins when it is the only request, or when ACK has used its burst.
  assign grant_data = data_pend && (!ack_pend || (burst_reg >= ACK_BURST_W));
  assign grant_ack  = ack_pend && !grant_data;
  assign len_zero   = (bus.tx_len == 16'd0);
  assign len_big    = (bus.tx_len > MAX_LEN_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      burst_reg        <= '0;
      gap_reg          <= '0;
      wd_reg           <= '0;
      zero_len_reg     <= 1'b0;
      ack_re_reg       <= 1'b0;
      send_data_re_reg <= 1'b0;
      frm_start_reg    <= 1'b0;
      frm_kind_reg     <= 1'b0;
      frm_ack_reg      <= 1'b0;
      frm_len_reg      <= '0;
      frm_abort_reg    <= 1'b0;
      len_err_reg      <= 1'b0;
      frames_sent_reg  <= '0;
    end else begin
      // Strobes are one-cycle pulses unless a state re-asserts them.
      ack_re_reg       <= 1'b0;
      send_data_re_reg <= 1'b0;
      frm_start_reg    <= 1'b0;
      frm_abort_reg    <= 1'b0;
      len_err_reg      <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (!data_pend) begin
            burst_reg <= '0;
          end
          // The grant decision and the FIFO heads are registered here so the
          // pop strobe, len_err and the held fields all appear in POP.
          if (grant_data) begin
            send_data_re_reg <= 1'b1;
            frm_kind_reg     <= !len_zero;
            frm_ack_reg      <= 1'b0;
            frm_len_reg      <= len_big ? MAX_LEN_W : bus.tx_len;
            len_err_reg      <= len_big || len_zero;
            zero_len_reg     <= len_zero;
            burst_reg        <= '0;
            state_reg        <= S_POP;
          end else if (grant_ack) begin
            ack_re_reg   <= 1'b1;
            frm_kind_reg <= 1'b0;
            frm_ack_reg  <= bus.ack_data;
            frm_len_reg  <= '0;
            zero_len_reg <= 1'b0;
            if (data_pend && (burst_reg < ACK_BURST_W)) begin
              burst_reg <= burst_reg + 4'd1;
            end
            state_reg <= S_POP;
          end
        end

        S_POP: begin
          if (zero_len_reg) begin
            // Empty DATA request: it has been popped, nothing is launched.
            frm_kind_reg <= 1'b0;
            frm_len_reg  <= '0;
            zero_len_reg <= 1'b0;
            gap_reg      <= '0;
            state_reg    <= POST_FRAME;
          end else begin
            frm_start_reg <= 1'b1;
            state_reg     <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          wd_reg    <= 20'd1;
          state_reg <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          // frm_done has priority over a watchdog expiry on the same edge.
          if (bus.frm_done) begin
            frames_sent_reg <= frames_sent_reg + 16'd1;
            frm_kind_reg    <= 1'b0;
            frm_ack_reg     <= 1'b0;
            frm_len_reg     <= '0;
            gap_reg         <= '0;
            state_reg       <= POST_FRAME;
          end else if (wd_reg >= TO_LAST) begin
            frm_abort_reg <= 1'b1;
            frm_kind_reg  <= 1'b0;
            frm_ack_reg   <= 1'b0;
            frm_len_reg   <= '0;
            gap_reg       <= '0;
            state_reg     <= POST_FRAME;
          end else begin
            wd_reg <= wd_reg + 20'd1;
          end
        end

        S_GAP: begin
          if (gap_reg >= IFG_LAST) begin
            state_reg <= S_IDLE;
          end else begin
            gap_reg <= gap_reg + 8'd1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_re       = ack_re_reg;
  assign bus.send_data_re = send_data_re_reg;
  assign bus.frm_start    = frm_start_reg;
  assign bus.frm_kind     = frm_kind_reg;
  assign bus.frm_ack      = frm_ack_reg;
  assign bus.frm_len      = frm_len_reg;
  assign bus.frm_abort    = frm_abort_reg;
  assign bus.len_err      = len_err_reg;
  assign bus.frames_sent  = frames_sent_reg;

endmodule
